// File: rtl/vga_pkg.sv
// Shared types for the VGA framebuffer arbiter: grant decode, return tags and
// saturating statistics helpers.
package vga_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_VID,
        GNT_HWR,
        GNT_HRD
    } gnt_e;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_VID,
        TAG_HOST
    } tag_e;

    localparam int unsigned StatW = 16;

    // Only reads produce a return; host writes retire without a tag.
    function automatic tag_e gnt_to_tag(gnt_e g);
        case (g)
            GNT_VID: return TAG_VID;
            GNT_HRD: return TAG_HOST;
            default: return TAG_NONE;
        endcase
    endfunction

    function automatic logic [StatW-1:0] sat_inc(logic [StatW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_fb_rdtrack.sv
// Two-stage return-tag pipeline steering SRAM read data to the video or host
// port; each port's data holds its last returned word between returns.
module vga_fb_rdtrack
    import vga_pkg::*;
#(
    parameter int unsigned DW = 12
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  gnt_e          gnt_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          vid_rvalid_o,
    output logic [DW-1:0] vid_rdata_o,
    output logic          host_rvalid_o,
    output logic [DW-1:0] host_rdata_o
);

    tag_e          tag1_q, tag1_d;
    tag_e          tag2_q, tag2_d;
    logic [DW-1:0] vid_hold_q, vid_hold_d;
    logic [DW-1:0] host_hold_q, host_hold_d;

    always_comb begin
        tag1_d        = gnt_to_tag(gnt_i);
        tag2_d        = tag1_q;
        vid_rvalid_o  = (tag2_q == TAG_VID);
        host_rvalid_o = (tag2_q == TAG_HOST);
        // SRAM data is only valid in the return cycle, so pass it straight through.
        vid_rdata_o   = vid_rvalid_o ? mem_rdata_i : vid_hold_q;
        host_rdata_o  = host_rvalid_o ? mem_rdata_i : host_hold_q;
        vid_hold_d    = vid_rdata_o;
        host_hold_d   = host_rdata_o;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
            vid_hold_q  <= '0;
            host_hold_q <= '0;
        end else begin
            tag1_q      <= tag1_d;
            tag2_q      <= tag2_d;
            vid_hold_q  <= vid_hold_d;
            host_hold_q <= host_hold_d;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: video fetch has absolute priority over host.
// Define VGA_FB_ARB_STAT_EN to enable the host stall/wait statistics counters.
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned AW = 19,
    parameter int unsigned DW = 12
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic             vid_req,
    input  logic [AW-1:0]    vid_addr,
    output logic             vid_rvalid,
    output logic [DW-1:0]    vid_rdata,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [DW-1:0]    host_wdata,
    output logic             host_ack,
    output logic             host_rvalid,
    output logic [DW-1:0]    host_rdata,
    output logic             mem_ce,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic [StatW-1:0] host_stall_cnt,
    output logic [StatW-1:0] host_max_wait
);

    gnt_e          gnt;
    logic          mem_ce_q, mem_ce_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    always_comb begin
        if (vid_req) begin
            gnt = GNT_VID;
        end else if (host_req) begin
            gnt = host_we ? GNT_HWR : GNT_HRD;
        end else begin
            gnt = GNT_NONE;
        end
        // Ack is the grant itself, so the host can drop its request on the next edge.
        host_ack = ((gnt == GNT_HWR) || (gnt == GNT_HRD)) && !reset;
    end

    always_comb begin
        mem_ce_d    = (gnt != GNT_NONE);
        mem_we_d    = (gnt == GNT_HWR);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (gnt)
            GNT_VID: mem_addr_d = vid_addr;
            GNT_HWR: begin
                mem_addr_d  = host_addr;
                mem_wdata_d = host_wdata;
            end
            GNT_HRD: mem_addr_d = host_addr;
            default: ;
        endcase
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    vga_fb_rdtrack #(
        .DW (DW)
    ) u_rdtrack (
        .clk_i         (pixel_clk),
        .rst_i         (reset),
        .gnt_i         (gnt),
        .mem_rdata_i   (mem_rdata),
        .vid_rvalid_o  (vid_rvalid),
        .vid_rdata_o   (vid_rdata),
        .host_rvalid_o (host_rvalid),
        .host_rdata_o  (host_rdata)
    );

`ifdef VGA_FB_ARB_STAT_EN
    logic [StatW-1:0] stall_q, stall_d;
    logic [StatW-1:0] wait_q, wait_d;
    logic [StatW-1:0] max_q, max_d;

    always_comb begin
        stall_d = stall_q;
        wait_d  = '0;
        if (host_req && !host_ack) begin
            stall_d = sat_inc(stall_q);
            wait_d  = sat_inc(wait_q);
        end
        max_d = (wait_d > max_q) ? wait_d : max_q;
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            wait_q  <= '0;
            max_q   <= '0;
        end else begin
            stall_q <= stall_d;
            wait_q  <= wait_d;
            max_q   <= max_d;
        end
    end

    assign host_stall_cnt = stall_q;
    assign host_max_wait  = max_q;
`else
    assign host_stall_cnt = '0;
    assign host_max_wait  = '0;
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised bench for vga_fb_arbiter against a cycle-level reference of the
// grant/return rules plus a synchronous SRAM model.
module tb_vga_fb_arbiter;

    localparam int AW = 19;
    localparam int DW = 12;
`ifdef VGA_FB_ARB_STAT_EN
    localparam bit StatEn = 1'b1;
`else
    localparam bit StatEn = 1'b0;
`endif

    logic          pixel_clk = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [15:0]   host_stall_cnt;
    logic [15:0]   host_max_wait;

    vga_fb_arbiter #(
        .AW (AW),
        .DW (DW)
    ) dut (
        .pixel_clk      (pixel_clk),
        .reset          (reset),
        .vid_req        (vid_req),
        .vid_addr       (vid_addr),
        .vid_rvalid     (vid_rvalid),
        .vid_rdata      (vid_rdata),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_ack       (host_ack),
        .host_rvalid    (host_rvalid),
        .host_rdata     (host_rdata),
        .mem_ce         (mem_ce),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .host_stall_cnt (host_stall_cnt),
        .host_max_wait  (host_max_wait)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return DW'((int'(a) * 29) ^ 32'h5A5);
    endfunction

    // Environment SRAM: one-cycle read latency, contents preloaded by init_val.
    logic [DW-1:0] sram [int];
    always @(posedge pixel_clk) begin
        if (mem_ce) begin
            if (mem_we) sram[int'(mem_addr)] = mem_wdata;
            else mem_rdata <= sram.exists(int'(mem_addr)) ? sram[int'(mem_addr)] : init_val(mem_addr);
        end
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [int];
    int            t1, t2;               // 0 none, 1 video, 2 host
    logic [DW-1:0] d1, d2;
    logic          e_ce, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_vdata, e_hdata;
    int            m_stall, m_wait, m_max;
    bit            host_granted;
    int            vid_rv_seen;
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        t1 = 0; t2 = 0; d1 = '0; d2 = '0;
        e_ce = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_vdata = '0; e_hdata = '0;
        m_stall = 0; m_wait = 0; m_max = 0;
    endtask

    task automatic model_step();
        int g;
        bit ghost;
        g = 0;
        if (vid_req) g = 1;
        else if (host_req) g = host_we ? 2 : 3;
        ghost = (g == 2 || g == 3);
        if (reset) begin
            model_clear();
            ghost = 0;
        end
        check_eq("host_ack", 32'(host_ack), 32'(ghost));
        check_eq("mem_ce", 32'(mem_ce), 32'(e_ce));
        check_eq("mem_we", 32'(mem_we), 32'(e_we));
        check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        check_eq("vid_rvalid", 32'(vid_rvalid), 32'(t2 == 1));
        check_eq("host_rvalid", 32'(host_rvalid), 32'(t2 == 2));
        if (t2 == 1) e_vdata = d2;
        if (t2 == 2) e_hdata = d2;
        check_eq("vid_rdata", 32'(vid_rdata), 32'(e_vdata));
        check_eq("host_rdata", 32'(host_rdata), 32'(e_hdata));
        check_eq("rv_excl", 32'(vid_rvalid & host_rvalid), 32'd0);
        check_eq("stall_cnt", 32'(host_stall_cnt), StatEn ? 32'(m_stall) : 32'd0);
        check_eq("max_wait", 32'(host_max_wait), StatEn ? 32'(m_max) : 32'd0);
        if (vid_rvalid) vid_rv_seen++;
        host_granted = ghost;
        if (!reset) begin
            t2 = t1; d2 = d1; t1 = 0;
            e_ce = (g != 0);
            e_we = (g == 2);
            case (g)
                1: begin e_addr = vid_addr; t1 = 1; d1 = ref_read(vid_addr); end
                2: begin
                    e_addr = host_addr; e_wdata = host_wdata;
                    ref_mem[int'(host_addr)] = host_wdata;
                end
                3: begin e_addr = host_addr; t1 = 2; d1 = ref_read(host_addr); end
                default: ;
            endcase
            if (host_req && !ghost) begin
                if (m_stall < 16'hFFFF) m_stall++;
                if (m_wait < 16'hFFFF) m_wait++;
            end else begin
                m_wait = 0;
            end
            if (m_wait > m_max) m_max = m_wait;
        end
    endtask

    task automatic tick();
        @(negedge pixel_clk);
        model_step();
        @(posedge pixel_clk);
        cyc++;
        #1;
    endtask

    task automatic host_next(input int busy_pct, input int addr_max);
        if (host_granted) host_req = 1'b0;
        if (!host_req && $urandom_range(99) < busy_pct) begin
            host_req   = 1'b1;
            host_we    = 1'($urandom_range(1));
            host_addr  = AW'($urandom_range(addr_max));
            host_wdata = DW'($urandom);
        end
    endtask

    task automatic host_set(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    endtask

    initial begin
        reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        model_clear();
        host_granted = 0;
        vid_rv_seen = 0;
        repeat (2) tick();
        #1 reset = 1'b0;

        // Video-only scanline.
        for (int i = 0; i < 640; i++) begin
            vid_req = 1'b1; vid_addr = AW'(i);
            tick();
        end
        vid_req = 1'b0;
        repeat (3) tick();
        check_eq("vid_rv_count", 32'(vid_rv_seen), 32'd640);

        // Host write during blanking, then read it back.
        host_set(1'b1, AW'(32'h100), DW'(32'hABC));
        tick();
        host_req = 1'b0;
        repeat (3) tick();
        host_set(1'b0, AW'(32'h100), '0);
        tick();
        host_req = 1'b0;
        repeat (3) tick();

        // Collision: video wins, host read follows one cycle later.
        vid_req = 1'b1; vid_addr = AW'(5);
        host_set(1'b0, AW'(32'h200), '0);
        tick();
        check_eq("collide_wait", 32'(host_granted), 32'd0);
        vid_req = 1'b0;
        tick();
        check_eq("collide_ack", 32'(host_granted), 32'd1);
        host_req = 1'b0;
        repeat (3) tick();

        // Interleave: alternating video with a persistently busy host.
        for (int i = 0; i < 200; i++) begin
            vid_req = 1'(i & 1); vid_addr = AW'($urandom_range(1023));
            host_next(100, 1023);
            tick();
        end

        // Random traffic over a small window for read-after-write hits.
        for (int i = 0; i < 3000; i++) begin
            vid_req = ($urandom_range(3) != 0); vid_addr = AW'($urandom_range(255));
            host_next(60, 255);
            tick();
        end
        vid_req = 1'b0;
        if (host_granted) host_req = 1'b0;
        while (host_req) tick();
        repeat (3) tick();

        // Reset one cycle after a host read grant drops the return.
        host_set(1'b0, AW'(32'h200), '0);
        tick();
        host_req = 1'b0;
        #1 reset = 1'b1;
        repeat (2) tick();
        vid_req = 1'b1; vid_addr = AW'(7);
        #1 reset = 1'b0;
        tick();
        vid_req = 1'b0;
        repeat (4) tick();

        // Host held through a 100-cycle video burst.
        #1 reset = 1'b1;
        tick();
        #1 reset = 1'b0;
        host_set(1'b0, AW'(3), '0);
        for (int i = 0; i < 100; i++) begin
            vid_req = 1'b1; vid_addr = AW'(i);
            tick();
        end
        vid_req = 1'b0;
        tick();
        host_req = 1'b0;
        tick();
        check_eq("burst_stall", 32'(host_stall_cnt), StatEn ? 32'd100 : 32'd0);
        check_eq("burst_max", 32'(host_max_wait), StatEn ? 32'd100 : 32'd0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 19, framebuffer word-address width (640x480 = 307200 words).
REQ-002 SHALL have parameter DW, default 12, framebuffer data width (RGB444).
REQ-003 SHALL have port pixel_clk  input  1  the one clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports vid_req  input  1, vid_addr  input  AW; video fetch request and address.
REQ-006 SHALL have ports vid_rvalid  output  1, vid_rdata  output  DW; video read return.
REQ-007 SHALL have ports host_req  input  1, host_we  input  1, host_addr  input  AW, host_wdata  input  DW; host access.
REQ-008 SHALL have ports host_ack  output  1, host_rvalid  output  1, host_rdata  output  DW; host grant pulse and read return.
REQ-009 SHALL have ports mem_ce  output  1, mem_we  output  1, mem_addr  output  AW, mem_wdata  output  DW, mem_rdata  input  DW; synchronous single-port SRAM, read data valid one cycle after mem_ce.

Function
REQ-010 SHALL evaluate one grant per cycle: GNT_NONE, GNT_VID, GNT_HWR, GNT_HRD.
REQ-011 SHALL give vid_req absolute priority; host granted only in cycles with vid_req low.
REQ-012 SHALL pulse host_ack for exactly one cycle, in the grant cycle; host holds host_req/addr/we/wdata stable until host_ack.
REQ-013 SHALL register memory outputs: grant in cycle N drives mem_ce/mem_we/mem_addr/mem_wdata in cycle N+1.
REQ-014 SHALL deassert mem_ce and mem_we in cycles following GNT_NONE; mem_addr/mem_wdata hold last value.
REQ-015 SHALL carry a 2-stage return tag (NONE/VID/HOST) alongside each grant so read data routes to its owner.
REQ-016 SHALL assert vid_rvalid in cycle N+2 for a GNT_VID in cycle N, with vid_rdata = mem_rdata; total video latency 2 cycles.
REQ-017 SHALL assert host_rvalid in cycle N+2 for a GNT_HRD in cycle N, with host_rdata = mem_rdata.
REQ-018 SHALL never assert host_rvalid for writes; write completes at N+1 with mem_we=1.
REQ-019 SHALL sustain back-to-back video grants every cycle (one vid_rvalid per cycle at steady state).
REQ-020 SHALL not generate host_ack while host_req is low; a new host request needs host_req re-sampled high after ack.
REQ-021 SHALL hold vid_rdata/host_rdata at last returned value when corresponding rvalid is low.

Reset
REQ-022 SHALL on reset clear mem_ce, mem_we, host_ack, vid_rvalid, host_rvalid, both tag stages and mem_addr/mem_wdata/vid_rdata/host_rdata to 0.
REQ-023 SHALL drop in-flight returns on reset mid-operation; no rvalid after reset release for pre-reset grants.
REQ-024 SHALL accept grants in the first clock edge after reset deasserts.

Configuration
REQ-025 SHALL, with VGA_FB_ARB_STAT_EN defined, add outputs host_stall_cnt (16-bit) counting cycles with host_req high and no host_ack, saturating at 0xFFFF, cleared by reset.
REQ-026 SHALL, with VGA_FB_ARB_STAT_EN defined, add output host_max_wait (16-bit) holding longest single request wait in cycles, saturating.
REQ-027 SHALL, without VGA_FB_ARB_STAT_EN, omit the counters and drive both outputs to 0.

Structure
REQ-028 SHALL take grant enum (GNT_NONE/VID/HWR/HRD) and return-tag enum from shared package vga_pkg.
REQ-029 SHALL implement tag/return routing in one sub-module vga_fb_rdtrack; grant logic stays in top.

Verification
REQ-030 Video only: vid_req=1 for 640 cycles, vid_addr 0..639 -> mem_addr 0..639 from N+1, 640 vid_rvalid pulses from N+2, data match SRAM model.
REQ-031 Host write during blanking: vid_req=0, host_we=1, addr=0x100, wdata=0xABC -> host_ack cycle N, mem_we=1 addr=0x100 cycle N+1, no host_rvalid.
REQ-032 Collision: vid_req and host read (addr 0x200) same cycle, vid_req drops next cycle -> video granted first, host_ack one cycle later, host_rvalid with mem[0x200] two cycles after ack.
REQ-033 Interleave: alternating vid_req high/low with host_req held -> vid_rvalid and host_rvalid never same cycle, each data matches own address.
REQ-034 Reset mid-flight: assert reset one cycle after GNT_HRD -> no host_rvalid afterwards, all outputs 0.
REQ-035 With VGA_FB_ARB_STAT_EN: host_req held during 100-cycle vid burst -> host_stall_cnt=100, host_max_wait=100 after ack.
